// File: rtl/pkt_seq_gen_pkg.sv
`default_nettype none
// ============================================================================
// pkt_seq_gen_pkg : shared state codes and defaults for generator and checkers
// Rev 1.0
// ============================================================================
package pkt_seq_gen_pkg;

   localparam int          STATE_W       = 5;
   localparam int          WORD_SIZE_DEF = 4;
   localparam int          LEN_W_DEF     = 8;
   localparam logic [3:0]  TRAILER_DEF   = 4'hF;

   // F_ERROR and SEQ_ERROR are only entered by the checker side
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 5'h00,
      ST_FIRST_PKT = 5'h01,
      ST_SEQ_ERROR = 5'h0C,
      ST_F_ERROR   = 5'h0F,
      ST_REG_PKT   = 5'h1A,
      ST_DONE      = 5'h1F
   } state_t;

endpackage
`default_nettype wire

// File: rtl/pkt_seq_gen_if.sv
`default_nettype none
// ============================================================================
// pkt_seq_gen_if : control, handshake and word bus of the packet generator
// Rev 1.0
// ============================================================================
interface pkt_seq_gen_if
   import pkt_seq_gen_pkg::*;
#(
   parameter int WORD_SIZE = WORD_SIZE_DEF,
   parameter int LEN_W     = LEN_W_DEF
);
   logic                  start;
   logic                  stop;
   logic [LEN_W-1:0]      burst_len;
   logic                  inject_f_err;
   logic                  inject_seq_err;
   logic                  ready;
   logic [WORD_SIZE-1:0]  MSW;
   logic [WORD_SIZE-1:0]  LSW;
   logic                  valid;
   logic                  busy;
   logic                  done;
   logic [STATE_W-1:0]    active_state;
   logic [LEN_W-1:0]      pkt_count;

   // master: controller / downstream side
   modport master (
      output start, stop, burst_len, inject_f_err, inject_seq_err, ready,
      input  MSW, LSW, valid, busy, done, active_state, pkt_count
   );

   // slave: the generator itself
   modport slave (
      input  start, stop, burst_len, inject_f_err, inject_seq_err, ready,
      output MSW, LSW, valid, busy, done, active_state, pkt_count
   );
endinterface
`default_nettype wire

// File: rtl/pkt_seq_counter.sv
`default_nettype none
// ============================================================================
// pkt_seq_counter : WIDTH-bit wrapping sequence counter, clear beats inc
// Rev 1.0
// ============================================================================
module pkt_seq_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);
   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (inc) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign count = r_count;
endmodule
`default_nettype wire

// File: rtl/pkt_seq_gen.sv
`default_nettype none
// ============================================================================
// pkt_seq_gen : MSW/LSW burst generator with one-shot error injection
// Rev 1.0
// ============================================================================
module pkt_seq_gen
   import pkt_seq_gen_pkg::*;
#(
   parameter int                   WORD_SIZE = WORD_SIZE_DEF,
   parameter logic [WORD_SIZE-1:0] TRAILER   = WORD_SIZE'(TRAILER_DEF),
   parameter int                   LEN_W     = LEN_W_DEF
) (
   input  logic         clk,
   input  logic         reset,
   pkt_seq_gen_if.slave bus
);
   state_t               r_state, w_state_nxt;
   logic                 r_valid, w_valid_nxt;
   logic                 r_corr_f, w_corr_f_nxt;
   logic                 r_corr_s, w_corr_s_nxt;
   logic                 r_pend_f, w_pend_f_nxt;
   logic                 r_pend_s, w_pend_s_nxt;
   logic                 r_stop_pend, w_stop_pend_nxt;
   logic [LEN_W-1:0]     r_len, w_len_nxt;
   logic [LEN_W-1:0]     r_pkt_count, w_pkt_count_nxt;
   logic                 w_seq_clear, w_seq_inc;
   logic [WORD_SIZE-1:0] w_seq;

   logic                 w_busy, w_accept, w_corrupt;
   logic                 w_pend_f, w_pend_s, w_stop, w_last;
   logic [LEN_W:0]       w_cnt_plus1;
   logic [LEN_W-1:0]     w_cnt_sat;

   pkt_seq_counter #(.WIDTH(WORD_SIZE)) u_seq (
      .clk   (clk),
      .reset (reset),
      .clear (w_seq_clear),
      .inc   (w_seq_inc),
      .count (w_seq)
   );

   assign w_busy    = (r_state == ST_FIRST_PKT) || (r_state == ST_REG_PKT);
   assign w_accept  = r_valid && bus.ready;
   assign w_corrupt = r_corr_f || r_corr_s;
   // same-cycle inject/stop requests count as already pending
   assign w_pend_f  = r_pend_f    || (w_busy && bus.inject_f_err);
   assign w_pend_s  = r_pend_s    || (w_busy && bus.inject_seq_err);
   assign w_stop    = r_stop_pend || (w_busy && bus.stop);

   assign w_cnt_plus1 = {1'b0, r_pkt_count} + (LEN_W+1)'(1);
   assign w_cnt_sat   = (&r_pkt_count) ? r_pkt_count : w_cnt_plus1[LEN_W-1:0];
   assign w_last      = (r_len != '0) && (w_cnt_plus1 == {1'b0, r_len});

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_valid     <= 1'b0;
         r_corr_f    <= 1'b0;
         r_corr_s    <= 1'b0;
         r_pend_f    <= 1'b0;
         r_pend_s    <= 1'b0;
         r_stop_pend <= 1'b0;
         r_len       <= '0;
         r_pkt_count <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_valid     <= w_valid_nxt;
         r_corr_f    <= w_corr_f_nxt;
         r_corr_s    <= w_corr_s_nxt;
         r_pend_f    <= w_pend_f_nxt;
         r_pend_s    <= w_pend_s_nxt;
         r_stop_pend <= w_stop_pend_nxt;
         r_len       <= w_len_nxt;
         r_pkt_count <= w_pkt_count_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_valid_nxt     = r_valid;
      w_corr_f_nxt    = r_corr_f;
      w_corr_s_nxt    = r_corr_s;
      w_pend_f_nxt    = r_pend_f;
      w_pend_s_nxt    = r_pend_s;
      w_stop_pend_nxt = r_stop_pend;
      w_len_nxt       = r_len;
      w_pkt_count_nxt = r_pkt_count;
      w_seq_clear     = 1'b0;
      w_seq_inc       = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_state_nxt     = ST_FIRST_PKT;
               w_valid_nxt     = 1'b1;
               w_corr_f_nxt    = 1'b0;
               w_corr_s_nxt    = 1'b0;
               w_pend_f_nxt    = 1'b0;
               w_pend_s_nxt    = 1'b0;
               w_stop_pend_nxt = bus.stop;
               w_len_nxt       = bus.burst_len;
               w_pkt_count_nxt = '0;
               w_seq_clear     = 1'b1;
            end
         end

         ST_FIRST_PKT, ST_REG_PKT: begin
            w_pend_f_nxt    = w_pend_f;
            w_pend_s_nxt    = w_pend_s;
            w_stop_pend_nxt = w_stop;
            if (w_accept) begin
               w_pkt_count_nxt = w_cnt_sat;
               w_seq_clear     = w_corrupt;
               w_seq_inc       = !w_corrupt;
               if (w_last || w_stop) begin
                  w_state_nxt     = ST_DONE;
                  w_valid_nxt     = 1'b0;
                  w_corr_f_nxt    = 1'b0;
                  w_corr_s_nxt    = 1'b0;
                  w_pend_f_nxt    = 1'b0;
                  w_pend_s_nxt    = 1'b0;
                  w_stop_pend_nxt = 1'b0;
               end else begin
                  // corrupted word forces a resync, as the checker would
                  w_state_nxt  = w_corrupt ? ST_FIRST_PKT : ST_REG_PKT;
                  w_corr_f_nxt = w_pend_f;
                  w_corr_s_nxt = w_pend_s && !w_pend_f;
                  w_pend_f_nxt = 1'b0;
                  w_pend_s_nxt = 1'b0;
               end
            end
         end

         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   assign bus.MSW          = r_valid ? (r_corr_s ? (w_seq ^ WORD_SIZE'(1)) : w_seq) : '0;
   assign bus.LSW          = r_valid ? (r_corr_f ? ~TRAILER : TRAILER) : '0;
   assign bus.valid        = r_valid;
   assign bus.busy         = w_busy;
   assign bus.done         = (r_state == ST_DONE);
   assign bus.active_state = r_state;
   assign bus.pkt_count    = r_pkt_count;
endmodule
`default_nettype wire

// File: tb/tb_pkt_seq_gen.sv
`default_nettype none
// ============================================================================
// tb_pkt_seq_gen : directed self-checking bench for pkt_seq_gen
// Rev 1.0
// ============================================================================
module tb_pkt_seq_gen;
   import pkt_seq_gen_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   pkt_seq_gen_if bus ();

   pkt_seq_gen dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // {valid, busy, done, MSW, LSW, active_state}
   function automatic logic [15:0] obs();
      return {bus.valid, bus.busy, bus.done, bus.MSW, bus.LSW, bus.active_state};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.start = 0; bus.stop = 0; bus.burst_len = '0; bus.ready = 0;
      bus.inject_f_err = 0; bus.inject_seq_err = 0;
      step(); step();
      checks++;
      if (obs() !== 16'h0000) begin
         errors++; $display("FAIL reset_outputs: got %h want %h", obs(), 16'h0000);
      end
      checks++;
      if (bus.pkt_count !== 8'd0) begin
         errors++; $display("FAIL reset_pkt_count: got %0d want 0", bus.pkt_count);
      end
      reset = 1'b1;
      step();
   endtask

   task automatic test_burst4();
      bus.burst_len = 8'd4; bus.ready = 1; bus.start = 1;
      step();
      bus.start = 0;
      for (int i = 0; i < 4; i++) begin
         logic [15:0] exp;
         exp = {1'b1, 1'b1, 1'b0, 4'(i), 4'hF, (i == 0) ? 5'h01 : 5'h1A};
         checks++;
         if (obs() !== exp) begin
            errors++; $display("FAIL burst4_word%0d: got %h want %h", i, obs(), exp);
         end
         step();
      end
      checks++;
      if (obs() !== {3'b001, 4'h0, 4'h0, 5'h1F}) begin
         errors++; $display("FAIL burst4_done: got %h want %h", obs(), {3'b001, 8'h00, 5'h1F});
      end
      checks++;
      if (bus.pkt_count !== 8'd4) begin
         errors++; $display("FAIL burst4_count: got %0d want 4", bus.pkt_count);
      end
      step();
      checks++;
      if (obs() !== 16'h0000 || bus.pkt_count !== 8'd4) begin
         errors++; $display("FAIL burst4_idle: got %h/%0d want 0000/4", obs(), bus.pkt_count);
      end
   endtask

   task automatic test_wrap();
      bus.burst_len = 8'd20; bus.ready = 1; bus.start = 1;
      step();
      bus.start = 0;
      for (int k = 0; k < 20; k++) begin
         logic [15:0] exp;
         exp = {1'b1, 1'b1, 1'b0, 4'(k % 16), 4'hF, (k == 0) ? 5'h01 : 5'h1A};
         checks++;
         if (obs() !== exp) begin
            errors++; $display("FAIL wrap_word%0d: got %h want %h", k, obs(), exp);
         end
         step();
      end
      checks++;
      if (bus.done !== 1'b1 || bus.pkt_count !== 8'd20) begin
         errors++; $display("FAIL wrap_done: got done=%b cnt=%0d want done=1 cnt=20", bus.done, bus.pkt_count);
      end
      step();
   endtask

   task automatic test_stall();
      logic pat [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      int   exp_idx = 0;
      bus.burst_len = 8'd3; bus.ready = 0; bus.start = 1;
      step();
      bus.start = 0;
      for (int i = 0; i < 6; i++) begin
         logic [15:0] exp;
         exp = {1'b1, 1'b1, 1'b0, 4'(exp_idx), 4'hF, (exp_idx == 0) ? 5'h01 : 5'h1A};
         checks++;
         if (obs() !== exp) begin
            errors++; $display("FAIL stall_cycle%0d: got %h want %h", i, obs(), exp);
         end
         bus.ready = pat[i];
         step();
         if (pat[i]) exp_idx++;
      end
      checks++;
      if (obs() !== {3'b001, 8'h00, 5'h1F} || bus.pkt_count !== 8'd3) begin
         errors++; $display("FAIL stall_done: got %h/%0d want %h/3", obs(), bus.pkt_count, {3'b001, 8'h00, 5'h1F});
      end
      bus.ready = 0;
      step();
   endtask

   task automatic test_inject();
      bus.burst_len = 8'd6; bus.ready = 1; bus.start = 1;
      step();
      bus.start = 0;
      step();
      bus.inject_f_err = 1;
      step();
      bus.inject_f_err = 0;
      checks++;
      if (obs() !== {3'b110, 4'h2, 4'h0, 5'h1A}) begin
         errors++; $display("FAIL inj_f_word3: got %h want %h", obs(), {3'b110, 4'h2, 4'h0, 5'h1A});
      end
      step();
      checks++;
      if (obs() !== {3'b110, 4'h0, 4'hF, 5'h01}) begin
         errors++; $display("FAIL inj_f_resync: got %h want %h", obs(), {3'b110, 4'h0, 4'hF, 5'h01});
      end
      bus.inject_f_err = 1; bus.inject_seq_err = 1;
      step();
      bus.inject_f_err = 0; bus.inject_seq_err = 0;
      checks++;
      if (obs() !== {3'b110, 4'h1, 4'h0, 5'h1A}) begin
         errors++; $display("FAIL inj_both_word: got %h want %h", obs(), {3'b110, 4'h1, 4'h0, 5'h1A});
      end
      step();
      checks++;
      if (obs() !== {3'b110, 4'h0, 4'hF, 5'h01}) begin
         errors++; $display("FAIL inj_both_resync: got %h want %h", obs(), {3'b110, 4'h0, 4'hF, 5'h01});
      end
      step();
      checks++;
      if (obs() !== {3'b001, 8'h00, 5'h1F} || bus.pkt_count !== 8'd6) begin
         errors++; $display("FAIL inj_done: got %h/%0d want %h/6", obs(), bus.pkt_count, {3'b001, 8'h00, 5'h1F});
      end
      step();
   endtask

   task automatic test_inject_stalled();
      bus.burst_len = 8'd0; bus.ready = 0; bus.start = 1;
      step();
      bus.start = 0;
      bus.inject_seq_err = 1;
      step();
      bus.inject_seq_err = 0;
      checks++;
      if (obs() !== {3'b110, 4'h0, 4'hF, 5'h01}) begin
         errors++; $display("FAIL injs_held_word: got %h want %h", obs(), {3'b110, 4'h0, 4'hF, 5'h01});
      end
      bus.ready = 1;
      step();
      checks++;
      if (obs() !== {3'b110, 4'h0, 4'hF, 5'h1A}) begin
         errors++; $display("FAIL injs_seq_word: got %h want %h", obs(), {3'b110, 4'h0, 4'hF, 5'h1A});
      end
      step();
      checks++;
      if (obs() !== {3'b110, 4'h0, 4'hF, 5'h01}) begin
         errors++; $display("FAIL injs_resync: got %h want %h", obs(), {3'b110, 4'h0, 4'hF, 5'h01});
      end
      bus.stop = 1;
      step();
      bus.stop = 0;
      checks++;
      if (obs() !== {3'b001, 8'h00, 5'h1F} || bus.pkt_count !== 8'd3) begin
         errors++; $display("FAIL injs_stop_done: got %h/%0d want %h/3", obs(), bus.pkt_count, {3'b001, 8'h00, 5'h1F});
      end
      bus.ready = 0;
      step();
   endtask

   task automatic test_stop_stalled();
      bus.burst_len = 8'd0; bus.ready = 1; bus.start = 1;
      step();
      bus.start = 0;
      step();
      bus.ready = 0; bus.stop = 1;
      step();
      bus.stop = 0;
      checks++;
      if (obs() !== {3'b110, 4'h1, 4'hF, 5'h1A}) begin
         errors++; $display("FAIL stop_held1: got %h want %h", obs(), {3'b110, 4'h1, 4'hF, 5'h1A});
      end
      step();
      checks++;
      if (obs() !== {3'b110, 4'h1, 4'hF, 5'h1A}) begin
         errors++; $display("FAIL stop_held2: got %h want %h", obs(), {3'b110, 4'h1, 4'hF, 5'h1A});
      end
      bus.ready = 1;
      step();
      checks++;
      if (obs() !== {3'b001, 8'h00, 5'h1F} || bus.pkt_count !== 8'd2) begin
         errors++; $display("FAIL stop_done: got %h/%0d want %h/2", obs(), bus.pkt_count, {3'b001, 8'h00, 5'h1F});
      end
      bus.ready = 0;
      step();
   endtask

   task automatic test_start_stop_idle();
      bus.burst_len = 8'd0; bus.ready = 0; bus.start = 1; bus.stop = 1;
      step();
      bus.stop = 0;
      checks++;
      if (obs() !== {3'b110, 4'h0, 4'hF, 5'h01}) begin
         errors++; $display("FAIL ss_first: got %h want %h", obs(), {3'b110, 4'h0, 4'hF, 5'h01});
      end
      step();
      bus.start = 0;
      checks++;
      if (obs() !== {3'b110, 4'h0, 4'hF, 5'h01}) begin
         errors++; $display("FAIL ss_start_busy: got %h want %h", obs(), {3'b110, 4'h0, 4'hF, 5'h01});
      end
      bus.ready = 1;
      step();
      checks++;
      if (obs() !== {3'b001, 8'h00, 5'h1F} || bus.pkt_count !== 8'd1) begin
         errors++; $display("FAIL ss_done: got %h/%0d want %h/1", obs(), bus.pkt_count, {3'b001, 8'h00, 5'h1F});
      end
      bus.start = 1;
      step();
      bus.start = 0;
      checks++;
      if (obs() !== 16'h0000) begin
         errors++; $display("FAIL ss_start_in_done: got %h want 0000", obs());
      end
      bus.ready = 0;
      step();
   endtask

   task automatic test_reset_mid();
      bus.burst_len = 8'd0; bus.ready = 1; bus.start = 1;
      step();
      bus.start = 0;
      step(); step();
      reset = 1'b0;
      step();
      checks++;
      if (obs() !== 16'h0000 || bus.pkt_count !== 8'd0) begin
         errors++; $display("FAIL rst_mid1: got %h/%0d want 0000/0", obs(), bus.pkt_count);
      end
      step();
      checks++;
      if (obs() !== 16'h0000) begin
         errors++; $display("FAIL rst_mid2: got %h want 0000", obs());
      end
      reset = 1'b1;
      step();
      checks++;
      if (obs() !== 16'h0000) begin
         errors++; $display("FAIL rst_mid_release: got %h want 0000", obs());
      end
      bus.ready = 0;
   endtask

   initial begin
      test_reset();
      test_burst4();
      test_wrap();
      test_stall();
      test_inject();
      test_inject_stalled();
      test_stop_stalled();
      test_start_stop_idle();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
